// File: rtl/aes_block_ctrl_pkg.sv
// Shared types and constants for the AES block sequencing controller.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    localparam int ROUND_W            = 4;
    localparam int WDOG_W             = 8;
    localparam int DEFAULT_NUM_ROUNDS = 10;
    localparam int DEFAULT_TIMEOUT    = 64;

endpackage

// File: rtl/aes_block_ctrl_if.sv
// Handshake and datapath-control bundle between the controller and its surroundings.
interface aes_block_ctrl_if;
    import aes_ctrl_pkg::*;

    logic               atd_valid;
    logic               atd_ack;
    logic               round_start;
    logic               round_done;
    logic [ROUND_W-1:0] round_num;
    logic               data_reg_input;
    logic               data_reg_en;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               timeout_err;

    modport master (
        input  atd_valid, round_done, out_ready,
        output atd_ack, round_start, round_num, data_reg_input,
               data_reg_en, out_valid, busy, timeout_err
    );

    modport slave (
        output atd_valid, round_done, out_ready,
        input  atd_ack, round_start, round_num, data_reg_input,
               data_reg_en, out_valid, busy, timeout_err
    );

endinterface

// File: rtl/aes_block_ctrl_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-value flag.
module ctrl_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == TERM_VAL);

endmodule

// File: rtl/aes_block_ctrl.sv
// Sequences load, NUM_ROUNDS process passes and hand-off of one 128-bit block.
module aes_block_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    aes_block_ctrl_if.master bus
);

    state_t             r_state;
    state_t             w_next;
    logic               w_in_wait;
    logic               w_round_clr;
    logic               w_round_inc;
    logic               w_round_last;
    logic               w_wdog_clr;
    logic               w_wdog_inc;
    logic               w_wdog_last;
    logic [ROUND_W-1:0] w_round_num;
    logic [WDOG_W-1:0]  w_wdog_count_unused;

    assign w_in_wait   = (r_state == WAIT);
    assign w_round_clr = (r_state == IDLE) || (r_state == LOAD);
    assign w_round_inc = w_in_wait && bus.round_done && !w_round_last;
    // Watchdog only runs while a round is outstanding; round_done freezes it.
    assign w_wdog_clr  = !w_in_wait;
    assign w_wdog_inc  = w_in_wait && !bus.round_done;

    ctrl_counter #(
        .WIDTH    (ROUND_W),
        .TERMINAL (NUM_ROUNDS - 1)
    ) u_round_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_round_clr),
        .i_enable   (w_round_inc),
        .o_count    (w_round_num),
        .o_terminal (w_round_last)
    );

    ctrl_counter #(
        .WIDTH    (WDOG_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_wdog_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_wdog_clr),
        .i_enable   (w_wdog_inc),
        .o_count    (w_wdog_count_unused),
        .o_terminal (w_wdog_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.round_num = w_round_num;

    // round_done is checked before the watchdog so a simultaneous finish wins.
    always_comb begin
        w_next             = r_state;
        bus.atd_ack        = 1'b0;
        bus.round_start    = 1'b0;
        bus.data_reg_input = 1'b0;
        bus.data_reg_en    = 1'b0;
        bus.out_valid      = 1'b0;
        bus.timeout_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.atd_valid) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                bus.atd_ack     = 1'b1;
                bus.data_reg_en = 1'b1;
                w_next          = START;
            end
            START: begin
                bus.round_start = 1'b1;
                w_next          = WAIT;
            end
            WAIT: begin
                bus.data_reg_input = 1'b1;
                if (bus.round_done) begin
                    bus.data_reg_en = 1'b1;
                    w_next          = w_round_last ? DONE : START;
                end else if (w_wdog_last) begin
                    bus.timeout_err = 1'b1;
                    w_next          = IDLE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Randomized self-checking bench for aes_block_ctrl; expected timing comes from round-delay arithmetic.
module tb_aes_block_ctrl;
    import aes_ctrl_pkg::*;

    localparam int NR = 10;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_block_ctrl_if bus();

    aes_block_ctrl #(
        .NUM_ROUNDS (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Process-block stand-in: answers each round_start after the next queued delay.
    logic rd_auto   = 1'b0;
    logic rd_spur   = 1'b0;
    bit   rd_enable = 1'b0;
    int   rd_target = -1;
    int   dq[$];

    assign bus.round_done = rd_auto | rd_spur;

    always @(negedge clk) begin
        rd_auto = rd_enable && (cyc == rd_target);
        #1;
        if (rd_enable && bus.round_start) begin
            if (dq.size() > 0) rd_target = cyc + dq.pop_front();
            else               rd_target = cyc + 3;
        end
    end

    int ack_cnt, start_cnt, en_cnt, en_atd_cnt, en_nodone_cnt, err_cnt, valid_cnt, err_cyc;
    int ack_q[$];
    int valid_q[$];
    logic [ROUND_W-1:0] rn_q[$];
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        #1;
        if (bus.atd_ack) begin
            ack_cnt++;
            ack_q.push_back(cyc);
        end
        if (bus.round_start) begin
            start_cnt++;
            rn_q.push_back(bus.round_num);
        end
        if (bus.data_reg_en) begin
            en_cnt++;
            if (!bus.data_reg_input) en_atd_cnt++;
            if (bus.data_reg_input && !bus.round_done) en_nodone_cnt++;
        end
        if (bus.timeout_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.out_valid) begin
            valid_cnt++;
            if (!prev_valid) valid_q.push_back(cyc);
        end
        prev_valid = bus.out_valid;
    end

    task automatic clear_stats();
        ack_cnt = 0; start_cnt = 0; en_cnt = 0; en_atd_cnt = 0;
        en_nodone_cnt = 0; err_cnt = 0; valid_cnt = 0; err_cyc = -1;
        ack_q.delete();
        valid_q.delete();
        rn_q.delete();
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        outs = {bus.atd_ack, bus.round_start, bus.round_num, bus.data_reg_input,
                bus.data_reg_en, bus.out_valid, bus.busy, bus.timeout_err};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #2;
            outs = {bus.atd_ack, bus.round_start, bus.round_num, bus.data_reg_input,
                    bus.data_reg_en, bus.out_valid, bus.busy, bus.timeout_err};
            n_checks++;
            if (outs !== '0) begin
                n_errors++;
                $display("[TB] FAIL idle_outputs: got %b, expected 0", outs);
            end
        end

        clear_stats();
        dq.delete();
        dq.push_back(50);
        rd_enable = 1'b1;
        @(negedge clk);
        bus.atd_valid = 1'b1;
        @(negedge clk);
        bus.atd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        n_checks++;
        if (bus.data_reg_input !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL wait_mux_sel: got %b, expected 1", bus.data_reg_input);
        end
        rst = 1'b1;
        @(negedge clk);
        #2;
        n_checks++;
        if ({bus.busy, bus.round_num, bus.out_valid} !== 6'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_mid_wait: got busy=%b round_num=%0d out_valid=%b, expected all 0",
                     bus.busy, bus.round_num, bus.out_valid);
        end
        rst = 1'b0;
        rd_enable = 1'b0;
        rd_target = -1;
        repeat (6) @(negedge clk);
        #2;
        n_checks++;
        if (valid_cnt != 0 || ack_cnt != 1) begin
            n_errors++;
            $display("[TB] FAIL aborted_block: got valid=%0d acks=%0d, expected valid=0 acks=1",
                     valid_cnt, ack_cnt);
        end
    endtask

    // d_all>0 fixes every round delay; first_d>0 overrides round 0 only.
    task automatic test_single_block(input int ready_wait, input bit noisy,
                                     input int d_all, input int first_d);
        int dl[NR];
        int sum_d = 0;
        int base, exp_valid, xfer_cyc, idle_cyc, rn_bad;
        bit xfer = 1'b0;
        bit done_loop = 1'b0;
        logic [ROUND_W-1:0] rn_done = '0;
        xfer_cyc = -1;
        idle_cyc = -1;
        rn_bad   = 0;
        for (int i = 0; i < NR; i++) begin
            dl[i] = (d_all > 0) ? d_all : int'($urandom_range(1, 6));
            if (i == 0 && first_d > 0) dl[i] = first_d;
            sum_d += dl[i] + 1;
        end
        clear_stats();
        dq.delete();
        for (int i = 0; i < NR; i++) dq.push_back(dl[i]);
        rd_enable = 1'b1;
        @(negedge clk);
        base = cyc;
        exp_valid = base + 2 + sum_d;
        bus.atd_valid = 1'b1;
        bus.out_ready = (ready_wait == 0);
        rd_spur = noisy;
        for (int k = 0; k < 1000 && !done_loop; k++) begin
            @(negedge clk);
            bus.atd_valid = noisy && !xfer && ($urandom_range(0, 1) == 1);
            bus.out_ready = (ready_wait == 0) ||
                            (valid_q.size() > 0 && cyc >= valid_q[0] + ready_wait);
            rd_spur = noisy && !xfer && ($urandom_range(0, 1) == 1) &&
                      ((cyc == base + 1) || (valid_q.size() > 0 && cyc > valid_q[0]));
            #2;
            if (xfer && !bus.busy) begin
                idle_cyc  = cyc;
                done_loop = 1'b1;
            end else if (!xfer && bus.out_valid && bus.out_ready) begin
                xfer     = 1'b1;
                xfer_cyc = cyc;
                rn_done  = bus.round_num;
            end
        end
        bus.atd_valid = 1'b0;
        bus.out_ready = 1'b0;
        rd_spur       = 1'b0;

        n_checks++;
        if (!done_loop) begin
            n_errors++;
            $display("[TB] FAIL block_complete: got no return to idle within 1000 cycles, expected completion");
        end
        n_checks++;
        if (ack_cnt != 1 || ack_q.size() == 0 || ack_q[0] != base + 1) begin
            n_errors++;
            $display("[TB] FAIL atd_ack: got %0d pulses first at %0d, expected 1 at %0d",
                     ack_cnt, (ack_q.size() > 0) ? ack_q[0] - base : -1, 1);
        end
        n_checks++;
        if (start_cnt != NR) begin
            n_errors++;
            $display("[TB] FAIL round_start_count: got %0d, expected %0d", start_cnt, NR);
        end
        n_checks++;
        if (en_cnt != NR + 1 || en_atd_cnt != 1 || en_nodone_cnt != 0) begin
            n_errors++;
            $display("[TB] FAIL data_reg_en: got total=%0d atd=%0d stray=%0d, expected %0d/1/0",
                     en_cnt, en_atd_cnt, en_nodone_cnt, NR + 1);
        end
        n_checks++;
        if (valid_q.size() != 1 || valid_q[0] != exp_valid) begin
            n_errors++;
            $display("[TB] FAIL out_valid_cycle: got %0d, expected %0d",
                     (valid_q.size() > 0) ? valid_q[0] - base : -1, exp_valid - base);
        end
        n_checks++;
        if (valid_cnt != ready_wait + 1) begin
            n_errors++;
            $display("[TB] FAIL out_valid_hold: got %0d cycles, expected %0d", valid_cnt, ready_wait + 1);
        end
        for (int i = 0; i < NR; i++)
            if (i >= rn_q.size() || rn_q[i] != ROUND_W'(i)) rn_bad++;
        n_checks++;
        if (rn_bad != 0 || rn_done != ROUND_W'(NR - 1)) begin
            n_errors++;
            $display("[TB] FAIL round_num: got %0d bad indices, final %0d, expected 0 bad, final %0d",
                     rn_bad, rn_done, NR - 1);
        end
        n_checks++;
        if (xfer_cyc != exp_valid + ready_wait || idle_cyc != xfer_cyc + 1) begin
            n_errors++;
            $display("[TB] FAIL transfer_to_idle: got xfer=%0d idle=%0d, expected xfer=%0d idle=%0d",
                     xfer_cyc - base, idle_cyc - base, exp_valid + ready_wait - base,
                     exp_valid + ready_wait + 1 - base);
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_errors++;
            $display("[TB] FAIL no_timeout: got %0d timeout_err pulses, expected 0", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, base, exp_v1;
        bit got = 1'b0;
        d1 = $urandom_range(1, 5);
        d2 = $urandom_range(1, 5);
        clear_stats();
        dq.delete();
        for (int i = 0; i < NR; i++) dq.push_back(d1);
        for (int i = 0; i < NR; i++) dq.push_back(d2);
        rd_enable = 1'b1;
        @(negedge clk);
        base = cyc;
        exp_v1 = base + 2 + NR * (d1 + 1);
        bus.atd_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            #2;
            if (valid_q.size() >= 2) begin
                got = 1'b1;
                bus.atd_valid = 1'b0;
            end
        end
        bus.atd_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        #2;

        n_checks++;
        if (!got || bus.busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL b2b_complete: got blocks=%0d busy=%b, expected 2 and 0",
                     valid_q.size(), bus.busy);
        end
        n_checks++;
        if (valid_q.size() < 1 || valid_q[0] != exp_v1) begin
            n_errors++;
            $display("[TB] FAIL b2b_first_valid: got %0d, expected %0d",
                     (valid_q.size() > 0) ? valid_q[0] - base : -1, exp_v1 - base);
        end
        n_checks++;
        if (ack_q.size() != 2 || ack_q[1] != exp_v1 + 2) begin
            n_errors++;
            $display("[TB] FAIL b2b_second_ack: got %0d acks second at %0d, expected 2 at %0d",
                     ack_q.size(), (ack_q.size() > 1) ? ack_q[1] - base : -1, exp_v1 + 2 - base);
        end
        n_checks++;
        if (valid_q.size() != 2 || valid_q[1] != exp_v1 + 3 + NR * (d2 + 1) || valid_cnt != 2) begin
            n_errors++;
            $display("[TB] FAIL b2b_second_valid: got %0d (cycles %0d), expected %0d (cycles 2)",
                     (valid_q.size() > 1) ? valid_q[1] - base : -1, valid_cnt,
                     exp_v1 + 3 + NR * (d2 + 1) - base);
        end
    endtask

    task automatic test_watchdog();
        int sum_d = 0;
        int base, exp_err, idle_cyc, d;
        bit done_loop = 1'b0;
        idle_cyc = -1;
        clear_stats();
        dq.delete();
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(1, 6);
            dq.push_back(d);
            sum_d += d + 1;
        end
        dq.push_back(1000);
        rd_enable = 1'b1;
        @(negedge clk);
        base = cyc;
        exp_err = base + 2 + sum_d + TO;
        bus.atd_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.atd_valid = 1'b0;
        for (int k = 0; k < 400 && !done_loop; k++) begin
            @(negedge clk);
            #2;
            if (err_cnt > 0 && !bus.busy) begin
                idle_cyc  = cyc;
                done_loop = 1'b1;
            end
        end
        bus.out_ready = 1'b0;
        rd_target = -1;

        n_checks++;
        if (!done_loop || err_cnt != 1) begin
            n_errors++;
            $display("[TB] FAIL timeout_pulse: got %0d pulses, expected 1", err_cnt);
        end
        n_checks++;
        if (err_cyc != exp_err) begin
            n_errors++;
            $display("[TB] FAIL timeout_cycle: got %0d, expected %0d", err_cyc - base, exp_err - base);
        end
        n_checks++;
        if (idle_cyc != exp_err + 1) begin
            n_errors++;
            $display("[TB] FAIL timeout_idle: got %0d, expected %0d", idle_cyc - base, exp_err + 1 - base);
        end
        n_checks++;
        if (en_cnt != 5 || valid_cnt != 0 || start_cnt != 5) begin
            n_errors++;
            $display("[TB] FAIL timeout_side_effects: got en=%0d valid=%0d starts=%0d, expected 5/0/5",
                     en_cnt, valid_cnt, start_cnt);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.atd_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_block(5, 1'b0, 3, 0);
        repeat (4) test_single_block(int'($urandom_range(0, 4)), 1'b1, 0, 0);
        test_single_block(0, 1'b0, 0, TO);
        test_back_to_back();
        test_watchdog();
        test_single_block(1, 1'b1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
